instruction_fetch: RTL and testbench
====================================

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 SHALL have parameter UNIT_SEL, default 4'h1, instruction-memory unit select placed on address[15:12].
REQ-002 SHALL have parameter IMEM_DEPTH, default 15, number of valid instruction words.
REQ-003 SHALL have parameter START_PC, default 12'h000, first fetch address.
REQ-004 SHALL have parameter IDLE_ADDR, default 16'hF000, bus address driven when not fetching (unassigned unit).
REQ-005 SHALL have Clk  input  1  single system clock; all state changes on rising edge.
REQ-006 SHALL have nReset  input  1  asynchronous, active-low reset.
REQ-007 SHALL have start  input  1  begin or restart execution.
REQ-008 SHALL have address  output  16  shared address bus.
REQ-009 SHALL have nRead  output  1  active-low read strobe to instruction memory.
REQ-010 SHALL have InstrData  input  32  shared data bus carrying fetched instruction.
REQ-011 SHALL have instr_valid  output  1  decoded instruction is presented.
REQ-012 SHALL have instr_ready  input  1  execute stage accepts the instruction.
REQ-013 SHALL have opcode, dest, src1, src2  output  8 each  fields [31:24], [23:16], [15:8], [7:0].
REQ-014 SHALL have is_branch  output  1  opcode in 8'h20-8'h2F.
REQ-015 SHALL have branch_taken  input  1  and branch_target  input  12  next-PC override sampled on acceptance.
REQ-016 SHALL have pc  output  12  address of the presented or next-fetched word.
REQ-017 SHALL have halted  output  1  and fault  output  1  status flags.

Function
REQ-018 SHALL implement states IDLE, FETCH, ISSUE, HALT.
REQ-019 IDLE: start=1 SHALL load pc<=START_PC and go to FETCH.
REQ-020 FETCH: SHALL drive address={UNIT_SEL,pc} and nRead=0 for exactly one cycle; the memory latches on the intervening falling edge.
REQ-021 FETCH: if pc>=IMEM_DEPTH, SHALL not drive nRead low, SHALL set fault=1, and SHALL go to HALT.
REQ-022 The rising edge ending FETCH SHALL register InstrData into the instruction register and go to ISSUE, or to HALT when InstrData[31:24]==8'hFF (stop is never issued).
REQ-023 ISSUE: instr_valid=1; fields SHALL remain stable until instr_valid&instr_ready at a rising edge.
REQ-024 On acceptance, pc SHALL become branch_taken&is_branch ? branch_target : pc+1, and the state SHALL return to FETCH.
REQ-025 pc+1 SHALL be a 12-bit increment; out-of-range values are caught by REQ-021.
REQ-026 Outside FETCH, address SHALL equal IDLE_ADDR and nRead SHALL be 1, releasing the bus.
REQ-027 Latency SHALL be start edge -> FETCH cycle -> instr_valid in the following cycle, giving 2 cycles per instruction with instr_ready held at 1.
REQ-028 HALT: halted=1; start=1 SHALL clear halted and fault, load START_PC, and go to FETCH.
REQ-029 start SHALL be ignored in FETCH and ISSUE.
REQ-030 instr_ready SHALL be ignored outside ISSUE.

Reset
REQ-031 nReset low SHALL immediately force state=IDLE, pc=START_PC, address=IDLE_ADDR, nRead=1, instr_valid=0, all fields=0, is_branch=0, halted=0, fault=0, including mid-FETCH or mid-ISSUE.
REQ-032 Operation SHALL begin only on a start received after nReset deasserts.

Structure
REQ-033 A shared package SHALL hold the state enum, the opcode constants (STOP=8'hFF, MMULT1-3=8'h00-02, MADD=03, MSUB=04, MTRANSPOSE=05, MSCALE=06, MSCALEIMM=07, INTADD=10, INTSUB=11, INTMULT=12, INTDIV=13, branch range 20-2F), and the unit-select constants.
REQ-034 A combinational sub-module instr_decode SHALL split the instruction register into the four fields and produce is_branch and is_stop.

Verification
REQ-035 Reset then start; memory returns 32'h03020001 -> one cycle with address=16'h1000 and nRead=0, then instr_valid=1 with opcode=03, dest=02, src1=00, src2=01.
REQ-036 instr_ready held 0 for 3 cycles in ISSUE -> fields stable, nRead stays 1, address=16'hF000; accept -> next fetch at 16'h1001.
REQ-037 Accept 32'h22010403 with branch_taken=1 and branch_target=12'h006 -> next FETCH address=16'h1006; with branch_taken=1 on non-branch 32'h10100A0B -> pc+1.
REQ-038 Fetch 32'hFF000000 -> instr_valid never asserts, halted=1; start -> halted=0 and fetch at 16'h1000.
REQ-039 Sequential accepts reaching pc=15 -> no nRead pulse, fault=1, halted=1.
REQ-040 nReset pulsed low during FETCH -> nRead=1, address=16'hF000, instr_valid=0 asynchronously; no activity until the next start.

Source files
------------

// File: rtl/instruction_fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
// Opcode map, unit selects and the fetch FSM state encoding.
package instruction_fetch_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_ISSUE,
        S_HALT
    } if_state_t;

    localparam logic [7:0] OP_STOP       = 8'hFF;
    localparam logic [7:0] OP_MMULT1     = 8'h00;
    localparam logic [7:0] OP_MMULT2     = 8'h01;
    localparam logic [7:0] OP_MMULT3     = 8'h02;
    localparam logic [7:0] OP_MADD       = 8'h03;
    localparam logic [7:0] OP_MSUB       = 8'h04;
    localparam logic [7:0] OP_MTRANSPOSE = 8'h05;
    localparam logic [7:0] OP_MSCALE     = 8'h06;
    localparam logic [7:0] OP_MSCALEIMM  = 8'h07;
    localparam logic [7:0] OP_INTADD     = 8'h10;
    localparam logic [7:0] OP_INTSUB     = 8'h11;
    localparam logic [7:0] OP_INTMULT    = 8'h12;
    localparam logic [7:0] OP_INTDIV     = 8'h13;
    localparam logic [7:0] OP_BRANCH_LO  = 8'h20;
    localparam logic [7:0] OP_BRANCH_HI  = 8'h2F;

    localparam logic [3:0] UNIT_IMEM = 4'h1;
    localparam logic [3:0] UNIT_NONE = 4'hF;

    function automatic logic is_branch_op(input logic [7:0] op);
        return (op >= OP_BRANCH_LO) && (op <= OP_BRANCH_HI);
    endfunction

endpackage

// File: rtl/instruction_fetch_decode.sv
// Combinational split of the instruction register into fields.
// Also flags branch-class and stop opcodes.
module instr_decode
    import instruction_fetch_pkg::*;
(
    input  logic [31:0] i_instr,
    output logic [7:0]  o_opcode,
    output logic [7:0]  o_dest,
    output logic [7:0]  o_src1,
    output logic [7:0]  o_src2,
    output logic        o_is_branch,
    output logic        o_is_stop
);

    // Field extraction and opcode classification
    always_comb begin
        o_opcode    = i_instr[31:24];
        o_dest      = i_instr[23:16];
        o_src1      = i_instr[15:8];
        o_src2      = i_instr[7:0];
        o_is_branch = is_branch_op(i_instr[31:24]);
        o_is_stop   = (i_instr[31:24] == OP_STOP);
    end

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch unit: reads words over the shared bus, presents
// decoded instructions with a valid/ready handshake, handles branches.
module instruction_fetch
    import instruction_fetch_pkg::*;
#(
    parameter logic [3:0]  UNIT_SEL   = 4'h1,
    parameter int          IMEM_DEPTH = 15,
    parameter logic [11:0] START_PC   = 12'h000,
    parameter logic [15:0] IDLE_ADDR  = 16'hF000
) (
    input  logic        Clk,
    input  logic        nReset,
    input  logic        start,
    output logic [15:0] address,
    output logic        nRead,
    input  logic [31:0] InstrData,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [7:0]  opcode,
    output logic [7:0]  dest,
    output logic [7:0]  src1,
    output logic [7:0]  src2,
    output logic        is_branch,
    input  logic        branch_taken,
    input  logic [11:0] branch_target,
    output logic [11:0] pc,
    output logic        halted,
    output logic        fault
);

    if_state_t   r_state;
    if_state_t   w_state_nxt;
    logic [11:0] r_pc;
    logic [11:0] w_pc_nxt;
    logic [31:0] r_ir;
    logic        r_fault;
    logic        w_ld_pc;
    logic        w_ld_ir;
    logic        w_set_fault;
    logic        w_clr_fault;
    logic [15:0] w_addr;
    logic        w_nread;
    logic        w_valid;
    logic        w_in_range;
    logic        w_is_branch;
    logic        w_is_stop;

    instr_decode u_decode (
        .i_instr     (r_ir),
        .o_opcode    (opcode),
        .o_dest      (dest),
        .o_src1      (src1),
        .o_src2      (src2),
        .o_is_branch (w_is_branch),
        .o_is_stop   (w_is_stop)
    );

    assign w_in_range = (int'(r_pc) < IMEM_DEPTH);

    // State register
    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) r_state <= S_IDLE;
        else         r_state <= w_state_nxt;
    end

    // Next-state, bus strobes and datapath load enables
    always_comb begin
        w_state_nxt = r_state;
        w_addr      = IDLE_ADDR;
        w_nread     = 1'b1;
        w_valid     = 1'b0;
        w_ld_pc     = 1'b0;
        w_pc_nxt    = r_pc;
        w_ld_ir     = 1'b0;
        w_set_fault = 1'b0;
        w_clr_fault = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_FETCH;
                    w_ld_pc     = 1'b1;
                    w_pc_nxt    = START_PC;
                end
            end
            S_FETCH: begin
                if (!w_in_range) begin
                    w_state_nxt = S_HALT;
                    w_set_fault = 1'b1;
                end else begin
                    w_addr      = {UNIT_SEL, r_pc};
                    w_nread     = 1'b0;
                    w_ld_ir     = 1'b1;
                    w_state_nxt = (InstrData[31:24] == OP_STOP)
                                  ? S_HALT : S_ISSUE;
                end
            end
            S_ISSUE: begin
                // A stop word never reaches ISSUE; guard keeps it unissuable.
                w_valid = !w_is_stop;
                if (w_is_stop) begin
                    w_state_nxt = S_HALT;
                end else if (instr_ready) begin
                    w_state_nxt = S_FETCH;
                    w_ld_pc     = 1'b1;
                    w_pc_nxt    = (branch_taken && w_is_branch)
                                  ? branch_target : r_pc + 12'd1;
                end
            end
            S_HALT: begin
                if (start) begin
                    w_state_nxt = S_FETCH;
                    w_ld_pc     = 1'b1;
                    w_pc_nxt    = START_PC;
                    w_clr_fault = 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Program counter, instruction register and fault flag
    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            r_pc    <= START_PC;
            r_ir    <= '0;
            r_fault <= 1'b0;
        end else begin
            if (w_ld_pc)          r_pc    <= w_pc_nxt;
            if (w_ld_ir)          r_ir    <= InstrData;
            if (w_set_fault)      r_fault <= 1'b1;
            else if (w_clr_fault) r_fault <= 1'b0;
        end
    end

    assign address     = w_addr;
    assign nRead       = w_nread;
    assign instr_valid = w_valid;
    assign is_branch   = w_is_branch;
    assign pc          = r_pc;
    assign halted      = (r_state == S_HALT);
    assign fault       = r_fault;

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch with a negedge-latching
// instruction memory model and a queue of expected fetches/issues.
module tb_instruction_fetch;

    typedef struct packed {
        logic [15:0] addr;
        logic [31:0] instr;
    } exp_t;

    logic        Clk = 1'b0;
    logic        nReset = 1'b0;
    logic        start = 1'b0;
    logic [15:0] address;
    logic        nRead;
    logic [31:0] InstrData = '0;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [7:0]  opcode, dest, src1, src2;
    logic        is_branch;
    logic        branch_taken = 1'b0;
    logic [11:0] branch_target = '0;
    logic [11:0] pc;
    logic        halted;
    logic        fault;

    logic [31:0] mem [0:15];
    logic [31:0] obs_word;
    exp_t        sb [$];
    int          total = 0;
    int          bad = 0;

    assign obs_word = {opcode, dest, src1, src2};

    instruction_fetch dut (
        .Clk           (Clk),
        .nReset        (nReset),
        .start         (start),
        .address       (address),
        .nRead         (nRead),
        .InstrData     (InstrData),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready),
        .opcode        (opcode),
        .dest          (dest),
        .src1          (src1),
        .src2          (src2),
        .is_branch     (is_branch),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .pc            (pc),
        .halted        (halted),
        .fault         (fault)
    );

    always #5 Clk = ~Clk;

    // Memory latches the addressed word on the falling edge of a read
    always @(negedge Clk) begin
        if (nRead === 1'b0) InstrData <= mem[address[3:0]];
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic do_reset();
        nReset       = 1'b0;
        start        = 1'b0;
        instr_ready  = 1'b0;
        branch_taken = 1'b0;
        sb.delete();
        tick();
        tick();
        nReset = 1'b1;
        tick();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic test_reset();
        logic act;
        nReset = 1'b0;
        tick();
        total++;
        if ({address, nRead, instr_valid} !== {16'hF000, 1'b1, 1'b0}) begin
            bad++;
            $display("FAIL reset_bus got=%h/%b/%b exp=F000/1/0",
                     address, nRead, instr_valid);
        end
        total++;
        if ({obs_word, is_branch, halted, fault, pc} !== 47'h0) begin
            bad++;
            $display("FAIL reset_state got=%h br=%b h=%b f=%b pc=%h exp=0",
                     obs_word, is_branch, halted, fault, pc);
        end
        nReset = 1'b1;
        act = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (nRead !== 1'b1 || instr_valid !== 1'b0) act = 1'b1;
        end
        total++;
        if (act !== 1'b0) begin
            bad++;
            $display("FAIL reset_no_start_activity got=%b exp=0", act);
        end
    endtask

    task automatic test_basic();
        exp_t e;
        do_reset();
        mem[0] = 32'h03020001;
        sb.push_back('{16'h1000, 32'h03020001});
        pulse_start();
        total++;
        if ({address, nRead, instr_valid} !== {sb[0].addr, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL basic_fetch got=%h/%b/%b exp=%h/0/0",
                     address, nRead, instr_valid, sb[0].addr);
        end
        tick();
        e = sb.pop_front();
        total++;
        if (instr_valid !== 1'b1 || obs_word !== e.instr) begin
            bad++;
            $display("FAIL basic_issue got=%b/%h exp=1/%h",
                     instr_valid, obs_word, e.instr);
        end
        total++;
        if ({address, nRead, is_branch} !== {16'hF000, 1'b1, 1'b0}) begin
            bad++;
            $display("FAIL basic_bus_release got=%h/%b/%b exp=F000/1/0",
                     address, nRead, is_branch);
        end
    endtask

    task automatic test_stall_branch();
        logic bad_hold;
        do_reset();
        mem[0] = 32'h03020001;
        mem[1] = 32'h22010403;
        mem[6] = 32'h10100A0B;
        pulse_start();
        tick();
        bad_hold = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (obs_word !== 32'h03020001 || instr_valid !== 1'b1 ||
                nRead !== 1'b1 || address !== 16'hF000) bad_hold = 1'b1;
        end
        total++;
        if (bad_hold !== 1'b0) begin
            bad++;
            $display("FAIL stall_hold got=%h/%b/%b/%h exp=03020001/1/1/F000",
                     obs_word, instr_valid, nRead, address);
        end
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        total++;
        if ({address, nRead} !== {16'h1001, 1'b0}) begin
            bad++;
            $display("FAIL stall_next_fetch got=%h/%b exp=1001/0",
                     address, nRead);
        end
        tick();
        total++;
        if (obs_word !== 32'h22010403 || is_branch !== 1'b1) begin
            bad++;
            $display("FAIL branch_issue got=%h/%b exp=22010403/1",
                     obs_word, is_branch);
        end
        branch_taken  = 1'b1;
        branch_target = 12'h006;
        instr_ready   = 1'b1;
        tick();
        instr_ready  = 1'b0;
        branch_taken = 1'b0;
        total++;
        if ({address, nRead} !== {16'h1006, 1'b0}) begin
            bad++;
            $display("FAIL branch_taken got=%h/%b exp=1006/0",
                     address, nRead);
        end
        tick();
        total++;
        if (obs_word !== 32'h10100A0B || is_branch !== 1'b0) begin
            bad++;
            $display("FAIL nonbranch_issue got=%h/%b exp=10100A0B/0",
                     obs_word, is_branch);
        end
        branch_taken  = 1'b1;
        branch_target = 12'h009;
        instr_ready   = 1'b1;
        tick();
        instr_ready  = 1'b0;
        branch_taken = 1'b0;
        total++;
        if ({address, nRead} !== {16'h1007, 1'b0}) begin
            bad++;
            $display("FAIL nonbranch_pc_inc got=%h/%b exp=1007/0",
                     address, nRead);
        end
    endtask

    task automatic test_stop();
        logic seen_valid;
        do_reset();
        mem[0] = 32'hFF000000;
        pulse_start();
        seen_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (instr_valid !== 1'b0) seen_valid = 1'b1;
        end
        total++;
        if (seen_valid !== 1'b0 || halted !== 1'b1 || fault !== 1'b0) begin
            bad++;
            $display("FAIL stop_halt got=v%b h%b f%b exp=v0 h1 f0",
                     seen_valid, halted, fault);
        end
        mem[0] = 32'h04050607;
        pulse_start();
        total++;
        if ({halted, address, nRead} !== {1'b0, 16'h1000, 1'b0}) begin
            bad++;
            $display("FAIL stop_restart got=%b/%h/%b exp=0/1000/0",
                     halted, address, nRead);
        end
        tick();
        start = 1'b1;
        tick();
        tick();
        start = 1'b0;
        total++;
        if (instr_valid !== 1'b1 || nRead !== 1'b1 ||
            obs_word !== 32'h04050607) begin
            bad++;
            $display("FAIL start_ignored_issue got=%b/%b/%h exp=1/1/04050607",
                     instr_valid, nRead, obs_word);
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        int   n;
        do_reset();
        for (int i = 0; i < 16; i++) begin
            mem[i] = 32'h10000000 | 32'(i);
            if (i < 15) sb.push_back('{16'h1000 | 16'(i), mem[i]});
        end
        instr_ready = 1'b1;
        pulse_start();
        n = 0;
        while (halted !== 1'b1 && n < 80) begin
            if (nRead === 1'b0) begin
                total++;
                if (sb.size() == 0) begin
                    bad++;
                    $display("FAIL b2b_extra_read got=%h exp=none", address);
                end else if (address !== sb[0].addr) begin
                    bad++;
                    $display("FAIL b2b_fetch got=%h exp=%h",
                             address, sb[0].addr);
                end
            end
            if (instr_valid === 1'b1) begin
                total++;
                if (sb.size() == 0) begin
                    bad++;
                    $display("FAIL b2b_extra_issue got=%h exp=none", obs_word);
                end else begin
                    e = sb.pop_front();
                    if (obs_word !== e.instr) begin
                        bad++;
                        $display("FAIL b2b_issue got=%h exp=%h",
                                 obs_word, e.instr);
                    end
                end
            end
            tick();
            n++;
        end
        instr_ready = 1'b0;
        total++;
        if (n >= 80) begin
            bad++;
            $display("FAIL b2b_timeout got=%0d cycles exp=<80", n);
        end
        total++;
        if (sb.size() != 0 || fault !== 1'b1 || halted !== 1'b1 ||
            nRead !== 1'b1) begin
            bad++;
            $display("FAIL b2b_fault got=left%0d f%b h%b r%b exp=left0 f1 h1 r1",
                     sb.size(), fault, halted, nRead);
        end
        pulse_start();
        total++;
        if ({fault, halted, address} !== {1'b0, 1'b0, 16'h1000}) begin
            bad++;
            $display("FAIL b2b_restart got=%b/%b/%h exp=0/0/1000",
                     fault, halted, address);
        end
    endtask

    task automatic test_reset_mid();
        logic act;
        do_reset();
        mem[0] = 32'h03020001;
        pulse_start();
        #2 nReset = 1'b0;
        #1;
        total++;
        if ({nRead, address, instr_valid, pc} !== {1'b1, 16'hF000, 1'b0, 12'h0}) begin
            bad++;
            $display("FAIL reset_mid_fetch got=%b/%h/%b/%h exp=1/F000/0/000",
                     nRead, address, instr_valid, pc);
        end
        tick();
        nReset = 1'b1;
        act = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (nRead !== 1'b1 || instr_valid !== 1'b0) act = 1'b1;
        end
        total++;
        if (act !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid_quiet got=%b exp=0", act);
        end
        pulse_start();
        tick();
        #2 nReset = 1'b0;
        #1;
        total++;
        if ({instr_valid, obs_word, halted} !== {1'b0, 32'h0, 1'b0}) begin
            bad++;
            $display("FAIL reset_mid_issue got=%b/%h/%b exp=0/00000000/0",
                     instr_valid, obs_word, halted);
        end
        tick();
        nReset = 1'b1;
        tick();
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = '0;
        test_reset();
        test_basic();
        test_stall_branch();
        test_stop();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
